// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with run/pause toggle, synchronous clear/load
// and a one-cycle terminal-count pulse on wrap in either direction.
module bcd_updown_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 100
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start_pause,
  input  logic                cnt_en,
  input  logic                up_dn,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                running,
  output logic                tc,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_updown_counter: DIGITS must be 1..8");
  end
  if (MODULUS < 2 || longint'(MODULUS) > pow10(DIGITS)) begin : g_bad_modulus
    $error("bcd_updown_counter: MODULUS must be 2..10**DIGITS");
  end

  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] r;
    int           m;
    m = n;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m           = m / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

  // Packed valid BCD orders the same as its numeric value, so a plain compare
  // against MAX_BCD is enough once every digit is known to be 0..9.
  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok && (v <= MAX_BCD);
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic         sp_prev;
  logic         sp_edge;
  logic [W-1:0] count_n;
  logic         running_n;
  logic         tc_n;
  logic         load_err_n;

  always_comb begin
    sp_edge    = start_pause & ~sp_prev;
    running_n  = running ^ sp_edge;
    count_n    = count;
    tc_n       = 1'b0;
    load_err_n = 1'b0;
    if (clear) begin
      count_n = '0;
    end else if (load) begin
      if (bcd_valid(load_val)) count_n    = load_val;
      else                     load_err_n = 1'b1;
    end else if (running && cnt_en) begin
      // Step uses the pre-toggle running value so an edge and a step can coexist.
      if (up_dn) begin
        if (count == MAX_BCD) begin
          count_n = '0;
          tc_n    = 1'b1;
        end else begin
          count_n = bcd_inc(count);
        end
      end else begin
        if (count == '0) begin
          count_n = MAX_BCD;
          tc_n    = 1'b1;
        end else begin
          count_n = bcd_dec(count);
        end
      end
    end
  end

  // sp_prev resets high so a start_pause held through reset is not an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count    <= '0;
      running  <= 1'b0;
      tc       <= 1'b0;
      load_err <= 1'b0;
      sp_prev  <= 1'b1;
    end else begin
      count    <= count_n;
      running  <= running_n;
      tc       <= tc_n;
      load_err <= load_err_n;
      sp_prev  <= start_pause;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: two instances (MODULUS 100 and 60) share stimulus
// and are compared against an integer-arithmetic reference model every cycle.
module tb_bcd_updown_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_pause = 1'b1;
  logic       cnt_en = 1'b0;
  logic       up_dn = 1'b1;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;

  logic [7:0] cnt100, cnt60;
  logic       run100, run60, tc100, tc60, err100, err60;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state: plain integers, not BCD
  int m100, m60;
  bit mtc100, mtc60, merr100, merr60, m_run, m_sp;

  always #5 clock = ~clock;

  bcd_updown_counter #(.DIGITS(2), .MODULUS(100)) dut100 (
    .clock(clock), .reset(reset), .start_pause(start_pause), .cnt_en(cnt_en),
    .up_dn(up_dn), .clear(clear), .load(load), .load_val(load_val),
    .count(cnt100), .running(run100), .tc(tc100), .load_err(err100)
  );

  bcd_updown_counter #(.DIGITS(2), .MODULUS(60)) dut60 (
    .clock(clock), .reset(reset), .start_pause(start_pause), .cnt_en(cnt_en),
    .up_dn(up_dn), .clear(clear), .load(load), .load_val(load_val),
    .count(cnt60), .running(run60), .tc(tc60), .load_err(err60)
  );

  function automatic logic [7:0] tobcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  function automatic logic [21:0] exp_vec();
    return {tobcd(m100), mtc100, merr100, tobcd(m60), mtc60, merr60, m_run, m_run};
  endfunction

  wire [21:0] act_vec = {cnt100, tc100, err100, cnt60, tc60, err60, run100, run60};

  task automatic model_reset();
    m100 = 0; m60 = 0; mtc100 = 0; mtc60 = 0; merr100 = 0; merr60 = 0;
    m_run = 0; m_sp = 1;
  endtask

  task automatic model_one(input int M, input int c, output int c_n, output bit t_n, output bit e_n);
    int hi, lo;
    hi  = int'(load_val[7:4]);
    lo  = int'(load_val[3:0]);
    c_n = c; t_n = 0; e_n = 0;
    if (clear) c_n = 0;
    else if (load) begin
      if (hi <= 9 && lo <= 9 && hi * 10 + lo < M) c_n = hi * 10 + lo;
      else e_n = 1;
    end else if (m_run && cnt_en) begin
      if (up_dn) begin t_n = (c == M - 1); c_n = (c + 1) % M; end
      else       begin t_n = (c == 0);     c_n = (c + M - 1) % M; end
    end
  endtask

  // Advance the model with the inputs the DUT is about to sample, then clock.
  task automatic tick();
    int n; bit t, e;
    model_one(100, m100, n, t, e); m100 = n; mtc100 = t; merr100 = e;
    model_one(60, m60, n, t, e);   m60 = n;  mtc60 = t;  merr60 = e;
    m_run = m_run ^ (start_pause & ~m_sp);
    m_sp  = start_pause;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    n_tests++;
    if (act_vec !== 22'h0) begin
      n_fail++; $display("FAIL reset_state got %h want %h", act_vec, 22'h0);
    end
  endtask

  task automatic test_start_hold();
    reset = 1'b0;
    repeat (3) begin
      tick();
      n_tests++;
      if (run100 !== 1'b0 || act_vec !== exp_vec()) begin
        n_fail++; $display("FAIL held_through_reset got %h want %h", act_vec, exp_vec());
      end
    end
    start_pause = 0; tick();
    start_pause = 1; tick();
    n_tests++;
    if (run100 !== 1'b1 || run60 !== 1'b1) begin
      n_fail++; $display("FAIL first_edge running got %b%b want 11", run100, run60);
    end
    start_pause = 0; tick();
    start_pause = 1; tick();
    n_tests++;
    if (run100 !== 1'b0 || act_vec !== exp_vec()) begin
      n_fail++; $display("FAIL second_edge got %h want %h", act_vec, exp_vec());
    end
    start_pause = 0; cnt_en = 1;
    repeat (3) tick();
    n_tests++;
    if (cnt100 !== 8'h00 || cnt60 !== 8'h00) begin
      n_fail++; $display("FAIL paused_frozen got %h/%h want 00/00", cnt100, cnt60);
    end
    cnt_en = 0;
  endtask

  task automatic test_count_up();
    start_pause = 1; tick();
    start_pause = 0;
    clear = 1; tick();
    clear = 0; cnt_en = 1; up_dn = 1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      n_tests++;
      if (cnt100 !== tobcd(i % 100) || tc100 !== (i == 100) || act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL count_up step %0d got cnt=%h tc=%b vec=%h want cnt=%h tc=%b vec=%h",
                 i, cnt100, tc100, act_vec, tobcd(i % 100), (i == 100), exp_vec());
      end
    end
    n_tests++;
    if (run100 !== 1'b1) begin
      n_fail++; $display("FAIL count_up running got %b want 1", run100);
    end
    cnt_en = 0;
  endtask

  task automatic test_load_down();
    load = 1; load_val = 8'h59; tick();
    load = 0;
    n_tests++;
    if (cnt60 !== 8'h59) begin
      n_fail++; $display("FAIL load59 got %h want 59", cnt60);
    end
    cnt_en = 1; up_dn = 0;
    for (int i = 58; i >= 0; i--) begin
      tick();
      n_tests++;
      if (cnt60 !== tobcd(i) || tc60 !== 1'b0 || act_vec !== exp_vec()) begin
        n_fail++; $display("FAIL down step to %0d got %h want %h", i, act_vec, exp_vec());
      end
    end
    tick();
    n_tests++;
    if (cnt60 !== 8'h59 || tc60 !== 1'b1) begin
      n_fail++; $display("FAIL down_wrap got cnt=%h tc=%b want cnt=59 tc=1", cnt60, tc60);
    end
    cnt_en = 0; tick();
    n_tests++;
    if (tc60 !== 1'b0 || cnt60 !== 8'h59) begin
      n_fail++; $display("FAIL tc_one_cycle got cnt=%h tc=%b want cnt=59 tc=0", cnt60, tc60);
    end
  endtask

  task automatic test_load_err();
    load = 1; load_val = 8'h5A; tick();
    n_tests++;
    if (err60 !== 1'b1 || err100 !== 1'b1 || cnt60 !== 8'h59) begin
      n_fail++; $display("FAIL load_5A got err=%b cnt=%h want err=1 cnt=59", err60, cnt60);
    end
    load_val = 8'h75; tick();
    n_tests++;
    if (err60 !== 1'b1 || cnt60 !== 8'h59 || err100 !== 1'b0 || cnt100 !== 8'h75) begin
      n_fail++; $display("FAIL load_75 got %h want %h", act_vec, exp_vec());
    end
    load_val = 8'h42; tick();
    n_tests++;
    if (err60 !== 1'b0 || cnt60 !== 8'h42 || act_vec !== exp_vec()) begin
      n_fail++; $display("FAIL load_42 got err=%b cnt=%h want err=0 cnt=42", err60, cnt60);
    end
    load = 0;
  endtask

  task automatic test_clear_load();
    load = 1; load_val = 8'h37; tick();
    clear = 1; load_val = 8'h25; cnt_en = 1; up_dn = 1; tick();
    n_tests++;
    if (cnt100 !== 8'h00 || cnt60 !== 8'h00 || run100 !== 1'b1 || tc100 !== 1'b0 || err100 !== 1'b0) begin
      n_fail++; $display("FAIL clear_over_load got %h want %h", act_vec, exp_vec());
    end
    clear = 0; load = 0; cnt_en = 0;
  endtask

  task automatic test_edge_step();
    cnt_en = 1; up_dn = 1;
    start_pause = 1; tick();
    n_tests++;
    if (cnt100 !== 8'h01 || run100 !== 1'b0) begin
      n_fail++; $display("FAIL edge_with_step got cnt=%h run=%b want cnt=01 run=0", cnt100, run100);
    end
    start_pause = 0; tick();
    start_pause = 1; tick();
    n_tests++;
    if (cnt100 !== 8'h01 || run100 !== 1'b1 || act_vec !== exp_vec()) begin
      n_fail++; $display("FAIL restart_no_step got %h want %h", act_vec, exp_vec());
    end
    start_pause = 0; cnt_en = 0;
  endtask

  task automatic test_async_reset();
    load = 1; load_val = 8'h62; tick();
    load = 0; cnt_en = 1; up_dn = 1; tick();
    n_tests++;
    if (cnt100 !== 8'h63 || run100 !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset got cnt=%h run=%b want cnt=63 run=1", cnt100, run100);
    end
    #2;
    reset = 1;
    model_reset();
    #1;
    n_tests++;
    if (cnt100 !== 8'h00 || run100 !== 1'b0 || act_vec !== 22'h0) begin
      n_fail++; $display("FAIL async_reset got %h want %h", act_vec, 22'h0);
    end
    @(posedge clock); #1;
    reset = 0; cnt_en = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      clear       = ($urandom_range(0, 31) == 0);
      load        = ($urandom_range(0, 11) == 0);
      load_val    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                : tobcd($urandom_range(0, 99));
      start_pause = ($urandom_range(0, 9) == 0);
      cnt_en      = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) up_dn = ~up_dn;
      tick();
      n_tests++;
      if (act_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random cycle %0d got %h want %h", i, act_vec, exp_vec());
      end
    end
    clear = 0; load = 0; start_pause = 0; cnt_en = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start_hold();
    test_count_up();
    test_load_down();
    test_load_err();
    test_clear_load();
    test_edge_step();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 2, number of BCD digits (legal 1..8).
REQ-002 SHALL have parameter MODULUS, default 100, count range 0..MODULUS-1 (legal 2..10^DIGITS); illegal values SHALL fail elaboration.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start_pause  input  1  run/pause toggle request, level-sampled, rising-edge acts.
REQ-006 SHALL have port cnt_en  input  1  count-enable qualifier for cascading and prescaling.
REQ-007 SHALL have port up_dn  input  1  direction, 1=up, 0=down.
REQ-008 SHALL have port clear  input  1  synchronous clear to 0.
REQ-009 SHALL have port load  input  1  synchronous parallel load.
REQ-010 SHALL have port load_val  input  4*DIGITS  BCD load value, digit 0 in bits [3:0].
REQ-011 SHALL have port count  output  4*DIGITS  registered BCD count, digit 0 in bits [3:0].
REQ-012 SHALL have port running  output  1  registered run state.
REQ-013 SHALL have port tc  output  1  registered terminal-count/wrap pulse.
REQ-014 SHALL have port load_err  output  1  registered rejected-load pulse.

Function
REQ-015 SHALL hold a registered previous sample sp_prev of start_pause; edge = start_pause & ~sp_prev.
REQ-016 SHALL toggle running on every detected edge, independent of clear, load and cnt_en.
REQ-017 SHALL apply per-cycle priority: clear > load > count step > hold.
REQ-018 clear SHALL set count to 0 next edge; running is unchanged; tc=0, load_err=0.
REQ-019 load SHALL accept load_val only if every digit is <=9 and value <MODULUS; accepted value appears on count next cycle.
REQ-020 A rejected load SHALL leave count unchanged, not step, and pulse load_err high for one cycle.
REQ-021 A count step SHALL occur only when running=1 and cnt_en=1 (the running value before any toggle this cycle).
REQ-022 Up step SHALL increment digit 0 and ripple carry: a digit at 9 goes to 0 and carries; digits never hold 10..15.
REQ-023 Up step at MODULUS-1 SHALL wrap count to 0 and set tc=1 in the same cycle count shows 0.
REQ-024 Down step SHALL decrement with borrow: a digit at 0 goes to 9 and borrows.
REQ-025 Down step at 0 SHALL wrap to MODULUS-1 in BCD and set tc=1 in the same cycle.
REQ-026 tc SHALL be high for exactly one cycle per wrap and low otherwise, including on load and clear cycles.
REQ-027 Direction changes SHALL take effect on the next step with no lost or extra counts.
REQ-028 An edge and a step in the same cycle SHALL both take effect: the step uses the old running value.
REQ-029 count SHALL always hold a valid BCD value <MODULUS.

Reset
REQ-030 reset=1 SHALL asynchronously force count=0, running=0, tc=0, load_err=0, sp_prev=1.
REQ-031 With sp_prev=1, start_pause held high through reset release SHALL NOT start the counter; a release followed by a new rising edge is required.
REQ-032 reset asserted mid-count or mid-load SHALL abort the operation with no partial digit update; deassertion SHALL be synchronised externally to clock.

Verification
REQ-033 DIGITS=2, MODULUS=100, pulse start_pause, up_dn=1, cnt_en=1 for 100 cycles -> count 00,01..09,10..99,00; tc high only on the 00 cycle; running=1.
REQ-034 MODULUS=60, load 0x59, down steps to 00, then one more step -> 58..00 then 59 with tc=1 for one cycle.
REQ-035 load_val=0x5A, then load_val=0x75 with MODULUS=60 -> count unchanged, load_err pulses both times; then load 0x42 -> count=0x42, load_err=0.
REQ-036 clear and load asserted together while running at 0x37 -> count=0x00 next cycle, running stays 1, tc=0.
REQ-037 start_pause held high across reset release -> running stays 0; low then high -> running=1 one cycle after the edge; second edge -> running=0, count frozen.
REQ-038 reset asserted asynchronously between clock edges at count 0x63 -> count=0, running=0 immediately, before the next clock edge.
